// File: rtl/xip_dbram_rd_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xip_dbram_pkg
//  Description : Shared types and helpers for the BRAM read streamer:
//                address-width helper, legal read latencies, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package xip_dbram_pkg;

  // Legal RAM read latencies (LOW_LATENCY / HIGH_PERFORMANCE RAM builds)
  localparam int LAT_LOW  = 1;
  localparam int LAT_HIGH = 2;

  // Streamer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of bits needed to represent 'value' (clogb2(511) = 9)
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xip_dbram_rd_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : xip_dbram_rd_streamer_if
//  Description : Command, RAM read-port and output-stream bundle of the
//                BRAM read streamer. The stride signal only exists when
//                XIP_DBRAM_RD_STRIDE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xip_dbram_rd_streamer_if
  import xip_dbram_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int LEN_W     = 10,
  parameter int RAM_WIDTH = 32
);
  // Command side
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [LEN_W-1:0]     len;
`ifdef XIP_DBRAM_RD_STRIDE_EN
  logic [ADDR_W-1:0]    stride;
`endif
  logic                 busy;
  logic                 done;
  // RAM read port
  logic [ADDR_W-1:0]    ram_addrb;
  logic                 ram_enb;
  logic [RAM_WIDTH-1:0] ram_doutb;
  // Output stream
  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  // Streamer view
  modport master (
`ifdef XIP_DBRAM_RD_STRIDE_EN
    input  stride,
`endif
    input  start, base_addr, len, ram_doutb, m_ready,
    output busy, done, ram_addrb, ram_enb, m_data, m_valid, m_last
  );

  // Environment view (commander, RAM and consumer)
  modport slave (
`ifdef XIP_DBRAM_RD_STRIDE_EN
    output stride,
`endif
    output start, base_addr, len, ram_doutb, m_ready,
    input  busy, done, ram_addrb, ram_enb, m_data, m_valid, m_last
  );

endinterface
`default_nettype wire

// File: rtl/xip_dbram_rd_streamer_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xip_skid_fifo
//  Description : Small synchronous FIFO absorbing RAM read data while the
//                stream is stalled. Push and pop may coincide when full.
//                DEPTH must be a power of 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module xip_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  // Storage write; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  // A push into a full FIFO without a simultaneous pop loses data
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push_i && full_o && !w_pop));
  end

endmodule
`default_nettype wire

// File: rtl/xip_dbram_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : xip_dbram_rd_streamer
//  Description : Burst read master for the simple-dual-port BRAM. Issues
//                credit-limited reads, tracks the fixed RAM latency and
//                streams words out through a skid FIFO.
//                Optional macro XIP_DBRAM_RD_STRIDE_EN adds a per-burst
//                address stride (otherwise the stride is 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module xip_dbram_rd_streamer
  import xip_dbram_pkg::*;
#(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 512,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 4,
  parameter int LEN_W      = 10
) (
  input logic                     clka,
  input logic                     rstb,
  xip_dbram_rd_streamer_if.master bus
);
  localparam int ADDR_W = clogb2(RAM_DEPTH - 1);
  localparam int FCW    = $clog2(SKID_DEPTH) + 1;
  localparam int CNT_W  = $clog2(SKID_DEPTH) + 2;

  generate
    if (RD_LATENCY != LAT_LOW && RD_LATENCY != LAT_HIGH) begin : g_bad_latency
      $error("RD_LATENCY must be 1 or 2");
    end
    if (SKID_DEPTH < RD_LATENCY + 1 || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0) begin : g_bad_skid
      $error("SKID_DEPTH must be a power of 2 and at least RD_LATENCY+1");
    end
  endgenerate

  state_e                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        issued_q;
  logic [LEN_W-1:0]        popped_q;
  logic [RD_LATENCY-1:0]   vld_q;
  logic [RD_LATENCY-1:0]   last_q;
  logic [ADDR_W-1:0]       w_step;
`ifdef XIP_DBRAM_RD_STRIDE_EN
  logic [ADDR_W-1:0]       stride_q;
  assign w_step = stride_q;
`else
  assign w_step = ADDR_W'(1);
`endif

  logic                    w_enb;
  logic                    w_is_last;
  logic                    w_pop;
  logic [CNT_W-1:0]        w_inflight;
  logic [RAM_WIDTH:0]      w_head;
  logic                    w_empty;
  logic                    w_full;
  logic [FCW-1:0]          w_count;

  // Reads still travelling through the RAM latency pipe
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + CNT_W'(vld_q[i]);
  end

  // A read is only issued when a FIFO slot is guaranteed for its data
  assign w_enb     = (state_q == RUN) && (issued_q < len_q) &&
                     ((w_inflight + CNT_W'(w_count)) < CNT_W'(SKID_DEPTH));
  assign w_is_last = (issued_q == len_q - LEN_W'(1));
  assign w_pop     = !w_empty && bus.m_ready;

  assign bus.ram_enb   = w_enb;
  assign bus.ram_addrb = addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.m_valid   = !w_empty;
  assign bus.m_data    = w_empty ? '0 : w_head[RAM_WIDTH-1:0];
  assign bus.m_last    = !w_empty && w_head[RAM_WIDTH];

  // Command FSM with address/issue/pop counters and registered busy/done
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
`ifdef XIP_DBRAM_RD_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (w_pop) popped_q <= popped_q + LEN_W'(1);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_q   <= bus.base_addr;
            len_q    <= bus.len;
            issued_q <= '0;
            popped_q <= '0;
`ifdef XIP_DBRAM_RD_STRIDE_EN
            stride_q <= bus.stride;
`endif
            if (bus.len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_enb) begin
            addr_q   <= addr_q + w_step;
            issued_q <= issued_q + LEN_W'(1);
            if (w_is_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the cycle the final word leaves, so done follows it
          if ((popped_q + LEN_W'(w_pop)) == len_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM latency pipe: valid and last-tag travel with each issued read
  always_ff @(posedge clka) begin
    if (rstb) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= w_enb;
      last_q[0] <= w_enb && w_is_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  // Illegal command length and data loss checks
  always_ff @(posedge clka) begin
    if (!rstb) begin
      if (state_q == IDLE && bus.start) assert (bus.len <= LEN_W'(RAM_DEPTH));
      assert (!(vld_q[RD_LATENCY-1] && w_full && !w_pop));
    end
  end

  xip_skid_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clka),
    .rst     (rstb),
    .push_i  (vld_q[RD_LATENCY-1]),
    .data_i  ({last_q[RD_LATENCY-1], bus.ram_doutb}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

endmodule
`default_nettype wire

// File: doc/xip_dbram_rd_streamer.md
Name: xip_dbram_rd_streamer

Overview:
Read-side master for the team's simple-dual-port single-clock BRAM (32x512 configuration by default). Accepts a burst command (base address, length), drives the RAM read port (addrb/enb), absorbs the RAM's fixed 1- or 2-cycle read latency, and presents words on a valid/ready stream. Backpressure is handled by a small skid FIFO sized so no read data is ever dropped. Sits between the BRAM buffer and downstream compute/DMA consumers.

Parameters:
- RAM_WIDTH, 32, data word width; must match the RAM.
- RAM_DEPTH, 512, RAM entries; ADDR_W = clogb2(RAM_DEPTH-1) = 9.
- RD_LATENCY, 1, RAM read latency in cycles: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE; other values illegal (elaboration error).
- SKID_DEPTH, 4, skid FIFO entries; must be at least RD_LATENCY+1; power of 2.
- LEN_W, 10, width of the burst length field; lengths 0..RAM_DEPTH.

Ports:
- clka  in  1  clock
- rstb  in  1  synchronous active-high reset; the RAM's rstb is tied to the same net
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  first read address
- len  in  LEN_W  words to read
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at burst completion
- ram_addrb  out  ADDR_W  RAM read address
- ram_enb  out  1  RAM read enable
- ram_doutb  in  RAM_WIDTH  RAM read data
- m_data  out  RAM_WIDTH  stream data (FIFO head)
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  qualifies the final word of the burst

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters, in-flight pipe and FIFO cleared. Reset mid-burst aborts the burst with no done pulse; partially returned data is discarded.
- FSM states:
  - IDLE: start accepted -> latch base_addr and len. len==0 -> DONE; otherwise -> RUN. start outside IDLE is ignored.
  - RUN: issue reads. When all len reads are issued -> DRAIN.
  - DRAIN: wait for in-flight reads to land and the FIFO to empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy is 1 in RUN and DRAIN only.
- Issue rule: ram_enb=1 iff state==RUN, issued<len, and (inflight + fifo_count) < SKID_DEPTH. ram_enb is never asserted otherwise (power).
- Address: ram_addrb = base_addr + issued*stride, modulo RAM_DEPTH (natural ADDR_W wrap). 511 -> 0.
- Latency tracking: RD_LATENCY-deep valid shift register, with a last-tag alongside. Data captured from ram_doutb exactly RD_LATENCY cycles after the enb cycle and pushed into the FIFO.
- Minimum latency is start -> first m_valid = 1 + RD_LATENCY + 1 cycles (command latch, read, FIFO write).
- Throughput: 1 word/cycle sustained when m_ready is held high.
- Stream rule: m_data and m_last are stable while m_valid && !m_ready. A transfer occurs when m_valid && m_ready. The FIFO allows push and pop in the same cycle when full.
- m_last=1 only on word len-1.
- Occupancy: the credit check guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- Arithmetic: issued and popped counters are LEN_W wide. len>RAM_DEPTH is illegal (assertion), and the address wraps regardless.

Optional Feature:
- Macro XIP_DBRAM_RD_STRIDE_EN.
- Defined: adds input port stride [ADDR_W-1:0], latched at start. Address step = stride, modulo RAM_DEPTH. stride==0 rereads base_addr len times.
- Undefined: no port; stride is fixed at 1.

Decomposition:
- Package xip_dbram_pkg holds:
  - the clogb2 function
  - RD_LATENCY legal values (LAT_LOW=1, LAT_HIGH=2)
  - the FSM state enum (IDLE, RUN, DRAIN, DONE)
- One sub-module, xip_skid_fifo: parameterised width and depth, synchronous reset, push/pop/full/empty/count.

Test Plan:
- RD_LATENCY=1, RAM preloaded with addr+0x100, base=0, len=8, m_ready=1 -> words 0x100..0x107 on consecutive cycles; m_last on 0x107; done one cycle after the last transfer.
- RD_LATENCY=2, base=510, len=4 -> data from addresses 510, 511, 0, 1; ram_enb never exceeds SKID_DEPTH outstanding.
- len=8 with m_ready toggling 1 cycle on, 3 off -> all 8 words in order, none dropped or duplicated; FIFO never overflows; m_data stable while stalled.
- len=0 -> done pulses within 2 cycles of start; ram_enb and m_valid stay 0.
- rstb asserted mid-burst after 3 transfers -> next cycle all outputs 0 and no done; a following start (base=0, len=2) completes normally.
- XIP_DBRAM_RD_STRIDE_EN defined, base=4, stride=3, len=4 -> addresses 4, 7, 10, 13; stride=0 -> address 4 four times.
